uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one UART transmitter (TxUnit: send / active_flag / done_flag handshake) between NUM_REQ byte requesters, e.g. the CPU store path, a debug monitor and a loop-back responder.
- Accepts one byte at a time from the winning requester and registers it.
- Holds the transmitter's send level until the transmitter reports active, then waits for done before granting again.
- Sits between the requesters and the TxUnit data_in/send pins, in place of direct FIFO-to-send glue.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width passed to the transmitter.
- GAP_CYCLES, 2, idle clock cycles after each done before the next grant (0 allowed).
- TIMEOUT_CYCLES, 65535, watchdog limit in clock cycles (used only with the optional feature).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte-available; must stay high until accepted.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept strobe.
- tx_send  out  1  level to TxUnit send.
- tx_data  out  DATA_W  registered byte to TxUnit data_in.
- tx_active  in  1  TxUnit active_flag.
- tx_done  in  1  TxUnit done_flag.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently being served.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values (asynchronous): state=IDLE, tx_send=0, tx_data=0, grant_id=0, busy=0, timeout_err=0, req_ready=0, gap counter=0, round-robin pointer=0 (requester 0 has highest priority first).
- States: IDLE, SEND, WAIT_DONE, GAP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching upward from the pointer and wrapping at NUM_REQ-1 → 0.
  - req_ready[winner]=1 combinationally in the same cycle, only when the state is IDLE.
  - On that edge: tx_data ← winner's byte, grant_id ← winner, pointer ← winner+1 (mod NUM_REQ), state ← SEND.
  - No valid request: remain in IDLE, req_ready=0.
- SEND:
  - tx_send=1 as a registered output, high from the first SEND cycle.
  - The level is held across baud ticks until tx_active=1 is sampled; then tx_send←0 and state←WAIT_DONE.
  - tx_done seen in SEND is ignored.
- WAIT_DONE:
  - On tx_done=1: if GAP_CYCLES=0 go to IDLE, otherwise load the gap counter and go to GAP.
  - tx_active and tx_done high in the same cycle counts as done.
- GAP: count down GAP_CYCLES cycles, then go to IDLE.
- Latency:
  - req_valid high in IDLE at cycle t → req_ready at t, tx_send=1 at t+1.
  - After a done: next grant at done+1+GAP_CYCLES.
- Fairness: with all requesters valid, grants rotate 0,1,2,3,0,...; no requester waits more than NUM_REQ-1 bytes.
- Protocol and boundary rules:
  - tx_data and grant_id are stable from SEND entry until the next grant.
  - req_valid deasserting after acceptance has no effect; requests arriving in SEND, WAIT_DONE or GAP are held off (req_ready=0).
  - tx_done or tx_active asserted while in IDLE is ignored and does not start a grant.
  - Reset asserted mid-frame: all outputs return to reset values immediately and the in-flight byte is dropped. The TxUnit must share this reset.
  - NUM_REQ not a power of two: pointer wrap uses a compare, not bit truncation.

Optional Feature:
- Macro: UART_TX_SCHED_TIMEOUT_EN.
- Enabled:
  - A 16-bit cycle counter clears on SEND entry and runs through SEND and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: tx_send←0, timeout_err pulses high for 1 cycle, state←IDLE (no GAP), byte dropped; the pointer is already advanced.
- Disabled: no counter is generated, timeout_err is tied 0, and the scheduler waits indefinitely in SEND/WAIT_DONE.

Test Plan:
- Reset, then req_valid=4'b0001 with req_data[7:0]=8'hA5 → req_ready=4'b0001 for 1 cycle, tx_data=8'hA5, tx_send held high until the TxUnit model raises tx_active, grant_id=0.
- req_valid=4'b1111 held, bytes 8'h10/8'h21/8'h32/8'h43 → tx_data sequence 10,21,32,43,10; each grant exactly 1+GAP_CYCLES=3 cycles after the previous done.
- Pointer=2 and req_valid=4'b0011 → requester 0 is granted (wrap), then requester 1.
- Reset pulsed during WAIT_DONE → busy=0, tx_send=0, grant_id=0 in the same cycle; the next request from requesters 0 and 3 together grants requester 0.
- With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=100, tx_active never asserted → tx_send drops and timeout_err pulses at cycle 100 after SEND entry; the next valid requester is granted afterwards.
- Without the macro and the same stimulus → tx_send stays high for 1000 cycles and timeout_err stays 0.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Requester and TxUnit signal bundle for uart_tx_scheduler.
// master = scheduler side, slave = requesters + TxUnit side.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_send;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_active;
  logic                      tx_done;

  modport master (
    input  req_valid,
    input  req_data,
    input  tx_active,
    input  tx_done,
    output req_ready,
    output tx_send,
    output tx_data
  );

  modport slave (
    output req_valid,
    output req_data,
    output tx_active,
    output tx_done,
    input  req_ready,
    input  tx_send,
    input  tx_data
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART TxUnit among NUM_REQ requesters.
// Optional watchdog abort: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clock,
  input  logic                       reset,
  uart_tx_scheduler_if.master        bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       w_ptr_nxt;
  logic [GW-1:0]       r_gap;
  logic [GW-1:0]       w_gap_nxt;
  logic                r_send;
  logic                w_send_nxt;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [PW-1:0]       r_grant;
  logic [PW-1:0]       w_grant_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic                w_win_vld;
  logic [PW-1:0]       w_win_id;
  logic [PW:0]         w_sum;
  logic [PW-1:0]       w_win_inc;
  logic [NUM_REQ-1:0]  w_ready;
  logic [DATA_W-1:0]   w_win_data;
  logic                w_tmo_hit;

  // Search upward from the pointer; wrap by compare so odd NUM_REQ works.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    w_sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NUM_REQ))
        w_sum = w_sum - (PW+1)'(NUM_REQ);
      if (!w_win_vld && bus.req_valid[w_sum[PW-1:0]]) begin
        w_win_vld = 1'b1;
        w_win_id  = w_sum[PW-1:0];
      end
    end
  end

  assign w_win_inc = (w_win_id == PW'(NUM_REQ - 1)) ?
                     '0 : w_win_id + PW'(1);

  assign w_win_data =
    bus.req_data[int'(w_win_id)*DATA_W +: DATA_W];

  assign w_ready = (r_state == S_IDLE && w_win_vld) ?
                   (NUM_REQ'(1) << w_win_id) : '0;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [15:0] r_tmo;

  assign w_tmo_hit = (r_tmo == 16'(TIMEOUT_CYCLES - 1));

  // Held at zero in IDLE so it reads 0 on the first SEND cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_tmo <= '0;
    else if (r_state == S_SEND || r_state == S_WAIT)
      r_tmo <= r_tmo + 16'd1;
    else
      r_tmo <= '0;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gap_nxt   = r_gap;
    w_send_nxt  = r_send;
    w_data_nxt  = r_data;
    w_grant_nxt = r_grant;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_data_nxt  = w_win_data;
          w_grant_nxt = w_win_id;
          w_ptr_nxt   = w_win_inc;
          w_send_nxt  = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.tx_active) begin
          w_send_nxt  = 1'b0;
          w_state_nxt = S_WAIT;
        end else if (w_tmo_hit) begin
          w_send_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.tx_done) begin
          if (GAP_CYCLES == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_gap_nxt   = GW'(GAP_CYCLES);
            w_state_nxt = S_GAP;
          end
        end else if (w_tmo_hit) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap <= GW'(1)) begin
          w_gap_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap - GW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gap   <= '0;
      r_send  <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gap   <= w_gap_nxt;
      r_send  <= w_send_nxt;
      r_data  <= w_data_nxt;
      r_grant <= w_grant_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.tx_send   = r_send;
  assign bus.tx_data   = r_data;
  assign busy          = (r_state != S_IDLE);
  assign grant_id      = r_grant;
  assign timeout_err   = r_err;

endmodule
